// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit for MULT/MULTU/DIV/DIVU with HI/LO registers.
// A radix-2 shift-add or restoring-divide loop over one shared 33-bit adder, with signs fixed up at the end.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        sa_q, sa_d;
    logic        bzero_q, bzero_d;
    logic [31:0] a_orig_q, a_orig_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [32:0] add_x, add_y, sum;
    logic        add_cin;
    logic        sgn_op, sgn_a, sgn_b;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // Shared adder: subtracts the divisor from the shifted remainder, or adds the multiplicand into the upper half.
    always_comb begin
        if (is_div_q) begin
            add_x   = prod_q[63:31];
            add_y   = ~{1'b0, mcand_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, prod_q[63:32]};
            add_y   = {1'b0, mcand_q};
            add_cin = 1'b0;
        end
        sum = add_x + add_y + {32'd0, add_cin};
    end

    // Next-state, datapath and output register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        bzero_d  = bzero_q;
        a_orig_d = a_orig_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sgn_op   = ~op[0];
        sgn_a    = sgn_op & a[31];
        sgn_b    = sgn_op & b[31];
        prod_fix = neg_q ? neg64(prod_q) : prod_q;
        quo_fix  = neg_q ? neg32(prod_q[31:0]) : prod_q[31:0];
        rem_fix  = sa_q ? neg32(prod_q[63:32]) : prod_q[63:32];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (hi_we) begin
                    hi_d = wdata;
                end else begin
                    hi_d = hi_q;
                end
                if (lo_we) begin
                    lo_d = wdata;
                end else begin
                    lo_d = lo_q;
                end
                if (start) begin
                    is_div_d = op[1];
                    sa_d     = sgn_a;
                    neg_d    = sgn_a ^ sgn_b;
                    bzero_d  = (b == 32'd0);
                    a_orig_d = a;
                    cnt_d    = 5'd0;
                    // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
                    if (op[1]) begin
                        mcand_d = sgn_b ? neg32(b) : b;
                        prod_d  = {32'd0, (sgn_a ? neg32(a) : a)};
                    end else begin
                        mcand_d = sgn_a ? neg32(a) : a;
                        prod_d  = {32'd0, (sgn_b ? neg32(b) : b)};
                    end
                    state_d = S_CALC;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (is_div_q) begin
                    if (!sum[32]) begin
                        prod_d = {sum[31:0], prod_q[30:0], 1'b1};
                    end else begin
                        prod_d = {prod_q[62:0], 1'b0};
                    end
                end else begin
                    if (prod_q[0]) begin
                        prod_d = {sum, prod_q[31:1]};
                    end else begin
                        prod_d = {1'b0, prod_q[63:1]};
                    end
                end
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (bzero_q) begin
                    hi_d = a_orig_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_q == S_FIX);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            bzero_q  <= 1'b0;
            a_orig_q <= 32'd0;
            mcand_q  <= 32'd0;
            prod_q   <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            bzero_q  <= bzero_d;
            a_orig_q <= a_orig_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed spec cases plus random ops against an arithmetic model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rh, output logic [31:0] rl);
        logic [63:0] p;
        int q, r;
        case (o)
            2'b00: begin
                p = 64'(longint'($signed(x)) * longint'($signed(y)));
                rh = p[63:32]; rl = p[31:0];
            end
            2'b01: begin
                p = {32'd0, x} * {32'd0, y};
                rh = p[63:32]; rl = p[31:0];
            end
            2'b10: begin
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rh = 32'd0; rl = 32'h8000_0000;
                end else begin
                    q = int'($signed(x)) / int'($signed(y));
                    r = int'($signed(x)) % int'($signed(y));
                    rh = 32'(r); rl = 32'(q);
                end
            end
            default: begin
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF;
                end else begin
                    rh = x % y; rl = x / y;
                end
            end
        endcase
    endfunction

    // Called just after a negedge; returns at the negedge of the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit inject, input string tag);
        int nbusy;
        logic [31:0] mh, ml;
        model(o, x, y, mh, ml);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            if (inject && nbusy == 10) begin
                start = 1'b1; lo_we = 1'b1; wdata = 32'h0000_AAAA;
                op = 2'b01; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 32'(nbusy), 32'd33);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " hi"}, hi, mh);
        check({tag, " lo"}, lo, ml);
        exp_hi = mh; exp_lo = ml;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, " done_pulse_end"}, {31'd0, done}, 32'd0);
        check({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        repeat (2) @(negedge clk);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        check("multu_max hi_const", hi, 32'hFFFF_FFFE);
        check("multu_max lo_const", lo, 32'h0000_0001);
        idle_check("multu_max");
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg3x7");
        check("mult_neg3x7 lo_const", lo, 32'hFFFF_FFEB);
        idle_check("mult_neg3x7");
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
        check("mult_minmin hi_const", hi, 32'h4000_0000);
        idle_check("mult_minmin");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7_2");
        check("div_neg7_2 lo_const", lo, 32'hFFFF_FFFD);
        check("div_neg7_2 hi_const", hi, 32'hFFFF_FFFF);
        idle_check("div_neg7_2");
        do_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_100_7");
        check("divu_100_7 lo_const", lo, 32'd14);
        idle_check("divu_100_7");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check("div_ovf lo_const", lo, 32'h8000_0000);
        idle_check("div_ovf");
        do_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, "divu_zero");
        check("divu_zero hi_const", hi, 32'h0000_1234);
        idle_check("divu_zero");
        do_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, "div_zero_neg");
        idle_check("div_zero_neg");

        do_op(2'b00, 32'd12345, 32'hFFFF_FF85, 1'b1, "inject");
        idle_check("inject");
        lo_we = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo lo", lo, 32'h0000_AAAA);
        check("mtlo hi_hold", hi, exp_hi);
        hi_we = 1'b1; wdata = 32'h5555_0000;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi hi", hi, 32'h5555_0000);
        check("mthi lo_hold", lo, 32'h0000_AAAA);

        do_op(2'b11, 32'd1000, 32'd33, 1'b0, "b2b_first");
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "b2b_second");
        idle_check("b2b_second");

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 1) rb = 32'd0;
            if (i % 6 == 2) rb = rb >> $urandom_range(0, 31);
            if (i % 6 == 3) ra = ra >> $urandom_range(0, 31);
            do_op(ro, ra, rb, 1'b0, $sformatf("rand%0d_op%0d", i, ro));
            idle_check("rand");
        end

        start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset hi", hi, 32'd0);
        check("midreset lo", lo, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op(2'b01, 32'd3, 32'd5, 1'b0, "after_reset");
        check("after_reset lo_const", lo, 32'd15);
        check("after_reset hi_const", hi, 32'd0);
        idle_check("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
